// File: rtl/yarvi_uart_tx.sv
// yarvi_uart_tx: byte FIFO feeding an 8N1 UART serializer with registered line output.
module yarvi_uart_tx #(
  parameter int DIVISOR   = 868,
  parameter int FIFO_LOG2 = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       busy
);
  localparam int DEPTH = 2 ** FIFO_LOG2;
  localparam int CW = FIFO_LOG2 + 1;
  localparam int BW = $clog2(DIVISOR);
  localparam logic [BW-1:0] LOAD = BW'(DIVISOR - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  state_e state_q, state_d;
  logic [7:0] mem_q [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic serial_q, serial_d;
  logic push, pop, empty, bit_end;
  assign empty = count_q == '0;
  assign tx_ready = !count_q[FIFO_LOG2];
  assign push = tx_valid && tx_ready;
  assign bit_end = baud_q == '0;
  assign serial_out = serial_q;
  assign busy = (state_q != IDLE) || !empty;
  assign wr_ptr_d = push ? wr_ptr_q + FIFO_LOG2'(1) : wr_ptr_q;
  assign rd_ptr_d = pop ? rd_ptr_q + FIFO_LOG2'(1) : rd_ptr_q;
  assign count_d = count_q + CW'(push) - CW'(pop);
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end
  // A pop always starts a new frame: load the byte and drive the start bit.
  always_comb begin
    state_d = state_q;
    baud_d = bit_end ? baud_q : baud_q - BW'(1);
    idx_d = idx_q;
    shift_d = shift_q;
    serial_d = serial_q;
    pop = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = baud_q;
        serial_d = 1'b1;
        if (!empty) begin
          pop = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          serial_d = 1'b0;
          baud_d = LOAD;
          state_d = START;
        end
      end
      START: if (bit_end) begin
        serial_d = shift_q[0];
        idx_d = 3'd0;
        baud_d = LOAD;
        state_d = DATA;
      end
      DATA: if (bit_end) begin
        baud_d = LOAD;
        if (idx_q == 3'd7) begin
          serial_d = 1'b1;
          state_d = STOP;
        end else begin
          shift_d = shift_q >> 1;
          serial_d = shift_q[1];
          idx_d = idx_q + 3'd1;
        end
      end
      STOP: if (bit_end) begin
        if (!empty) begin
          pop = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          serial_d = 1'b0;
          baud_d = LOAD;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      baud_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      serial_q <= 1'b1;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      baud_q <= baud_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      serial_q <= serial_d;
    end
  end
endmodule

// File: tb/tb_yarvi_uart_tx.sv
// tb_yarvi_uart_tx: directed checks of two UART TX instances (DIVISOR 4 and 2) with a mid-bit sampling receiver.
module tb_yarvi_uart_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic rdy0, rdy1, ser0, ser1, busy0, busy1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [9:0] rx0_f[$], rx1_f[$];
  int rx0_t[$], rx1_t[$];
  typedef struct {int e; logic ser; logic bsy; logic rdy;} wv_t;
  typedef struct {logic [7:0] data; logic [9:0] frame;} dv_t;

  yarvi_uart_tx #(.DIVISOR(4), .FIFO_LOG2(2)) dut (
    .clock(clk), .reset(rst_n), .tx_valid(v0), .tx_data(d0),
    .tx_ready(rdy0), .serial_out(ser0), .busy(busy0));
  yarvi_uart_tx #(.DIVISOR(2), .FIFO_LOG2(2)) dut2 (
    .clock(clk), .reset(rst_n), .tx_valid(v1), .tx_data(d1),
    .tx_ready(rdy1), .serial_out(ser1), .busy(busy1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver per instance: frame starts on the first low sample, bits sampled mid-period.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    localparam int D = (g == 0) ? 4 : 2;
    logic line;
    int ph = 0;
    int t0 = 0;
    logic act = 1'b0;
    logic [9:0] fr = '0;
    assign line = (g == 0) ? ser0 : ser1;
    always begin
      @(posedge clk);
      #1;
      if (!rst_n) act = 1'b0;
      else begin
        if (!act && !line) begin
          act = 1'b1;
          ph = 0;
          t0 = cyc;
        end
        if (act) begin
          if (ph % D == D / 2) fr[ph / D] = line;
          ph++;
          if (ph == 10 * D) begin
            act = 1'b0;
            if (g == 0) begin rx0_f.push_back(fr); rx0_t.push_back(t0); end
            else begin rx1_f.push_back(fr); rx1_t.push_back(t0); end
          end
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(int g, int n);
    int i = 0;
    while (((g == 0) ? rx0_f.size() : rx1_f.size()) < n && i < 600) begin
      step();
      i++;
    end
    chk("frame_count", (g == 0) ? rx0_f.size() : rx1_f.size(), n);
  endtask

  task automatic push0(logic [7:0] b);
    logic r;
    int i = 0;
    d0 = b;
    v0 = 1'b1;
    do begin
      r = rdy0;
      step();
      i++;
    end while (!r && i < 200);
    v0 = 1'b0;
    chk("push_accepted", r, 1'b1);
  endtask

  initial begin
    wv_t wv[16];
    dv_t dv[4];
    int n, it, k;
    logic r, bad_s, bad_b;
    logic [7:0] cur;
    logic [7:0] acc[6];
    logic [7:0] mb[3];
    wv[0] = '{0, 1, 1, 1};   wv[1] = '{1, 0, 1, 1};   wv[2] = '{4, 0, 1, 1};
    wv[3] = '{5, 1, 1, 1};   wv[4] = '{8, 1, 1, 1};   wv[5] = '{9, 0, 1, 1};
    wv[6] = '{13, 1, 1, 1};  wv[7] = '{17, 0, 1, 1};  wv[8] = '{21, 1, 1, 1};
    wv[9] = '{25, 0, 1, 1};  wv[10] = '{29, 1, 1, 1}; wv[11] = '{33, 0, 1, 1};
    wv[12] = '{36, 0, 1, 1}; wv[13] = '{37, 1, 1, 1}; wv[14] = '{40, 1, 1, 1};
    wv[15] = '{41, 1, 0, 1};
    dv[0] = '{8'h00, 10'h200}; dv[1] = '{8'hFF, 10'h3FE};
    dv[2] = '{8'hA3, 10'h346}; dv[3] = '{8'h80, 10'h300};
    mb[0] = 8'h5A; mb[1] = 8'hC3; mb[2] = 8'h0F;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_ser", ser0, 1'b1);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_ready", rdy0, 1'b1);
    chk("rst_busy2", busy1, 1'b0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();

    // single byte 0x55, waveform table relative to the accepting edge
    rx0_f.delete(); rx0_t.delete();
    d0 = 8'h55;
    v0 = 1'b1;
    step();
    v0 = 1'b0;
    k = cyc;
    for (int i = 0; i < 16; i++) begin
      while (cyc - k < wv[i].e) step();
      chk($sformatf("wave_ser_e%0d", wv[i].e), ser0, wv[i].ser);
      chk($sformatf("wave_busy_e%0d", wv[i].e), busy0, wv[i].bsy);
      chk($sformatf("wave_rdy_e%0d", wv[i].e), rdy0, wv[i].rdy);
    end
    wait_frames(0, 1);
    chk("single_frame", rx0_f[0], 10'h2AA);

    // fill / backpressure with a stalled producer toggling its data
    rx0_f.delete(); rx0_t.delete();
    v0 = 1'b1;
    d0 = 8'h01;
    n = 0;
    it = 0;
    k = 0;
    while (n < 6 && it < 200) begin
      r = rdy0;
      cur = d0;
      step();
      it++;
      if (r) begin
        acc[n] = cur;
        if (n == 0) k = cyc;
        if (n == 5) chk("accept6_edge", cyc - k, 42);
        n++;
        if (n == 5) begin
          chk("accept5_edge", cyc - k, 4);
          chk("full_ready", rdy0, 1'b0);
        end
      end
      d0 = (n < 5) ? 8'(n + 1) : 8'h60 + 8'(cyc);
    end
    v0 = 1'b0;
    chk("accepted", n, 6);
    wait_frames(0, 6);
    for (int i = 0; i < 6 && i < rx0_f.size(); i++) begin
      chk($sformatf("fill_frame%0d", i), rx0_f[i], {1'b1, acc[i], 1'b0});
      chk($sformatf("fill_start%0d", i), rx0_t[i] - k, 1 + 40 * i);
    end

    // data integrity
    rx0_f.delete(); rx0_t.delete();
    for (int i = 0; i < 4; i++) push0(dv[i].data);
    wait_frames(0, 4);
    for (int i = 0; i < 4 && i < rx0_f.size(); i++)
      chk($sformatf("data_frame%0d", i), rx0_f[i], dv[i].frame);

    // asynchronous reset in data bit 3 of 0xA3 with two bytes queued
    repeat (5) step();
    rx0_f.delete(); rx0_t.delete();
    v0 = 1'b1;
    d0 = 8'hA3;
    step();
    k = cyc;
    d0 = 8'h11;
    step();
    d0 = 8'h22;
    step();
    v0 = 1'b0;
    while (cyc - k < 18) step();
    chk("pre_rst_bit3", ser0, 1'b0);
    chk("pre_rst_busy", busy0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ser", ser0, 1'b1);
    chk("async_rst_busy", busy0, 1'b0);
    chk("async_rst_ready", rdy0, 1'b1);
    repeat (2) step();
    #2 rst_n = 1'b1;
    bad_s = 1'b0;
    bad_b = 1'b0;
    repeat (60) begin
      step();
      if (ser0 !== 1'b1) bad_s = 1'b1;
      if (busy0 !== 1'b0) bad_b = 1'b1;
    end
    chk("post_rst_line_idle", bad_s, 1'b0);
    chk("post_rst_not_busy", bad_b, 1'b0);
    chk("post_rst_no_frame", rx0_f.size(), 0);

    // minimum divisor: three back-to-back frames of 20 cycles
    rx1_f.delete(); rx1_t.delete();
    v1 = 1'b1;
    d1 = mb[0];
    step();
    k = cyc;
    d1 = mb[1];
    step();
    d1 = mb[2];
    step();
    v1 = 1'b0;
    while (cyc - k < 60) step();
    chk("min_busy_e60", busy1, 1'b1);
    chk("min_stop_e60", ser1, 1'b1);
    step();
    chk("min_busy_e61", busy1, 1'b0);
    chk("min_line_e61", ser1, 1'b1);
    wait_frames(1, 3);
    for (int i = 0; i < 3 && i < rx1_f.size(); i++) begin
      chk($sformatf("min_frame%0d", i), rx1_f[i], {1'b1, mb[i], 1'b0});
      chk($sformatf("min_start%0d", i), rx1_t[i] - k, 1 + 20 * i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
